traffic_phase_sched: RTL

//   Two-road traffic-signal scheduler driving the board RGB LEDs: led4 = road A head, led5 = road B head.

---
 rtl/traffic_pkg.sv | 21 ++
 rtl/tick_gen.sv | 31 +++
 rtl/traffic_phase_sched.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/traffic_pkg.sv
// Shared encodings for the two-road traffic-phase scheduler.
// Latency: none (types and constants only).
// Backpressure: not applicable.
package traffic_pkg;

    typedef enum logic [2:0] {
        ALL_RED  = 3'd0,
        A_GREEN  = 3'd1,
        A_YELLOW = 3'd2,
        B_GREEN  = 3'd3,
        B_YELLOW = 3'd4,
        FLASH    = 3'd5
    } state_e;

    // Light codes are {r,g,b}; yellow is shown as red+green on the RGB heads.
    localparam logic [2:0] RED    = 3'b100;
    localparam logic [2:0] GREEN  = 3'b010;
    localparam logic [2:0] YELLOW = 3'b110;
    localparam logic [2:0] OFF    = 3'b000;

endpackage

// File: rtl/tick_gen.sv
// Prescaler producing a one-cycle tick every TICK_DIV clk cycles.
// Latency: first tick TICK_DIV edges after reset release.
// Backpressure: none; free-running.
module tick_gen #(
    parameter int TICK_DIV = 100_000_000
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        tick  = (cnt_q == LAST);
        cnt_d = tick ? '0 : cnt_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/traffic_phase_sched.sv
// Two-road signal scheduler with all-red clearance; NIGHT_FLASH_EN adds night port and FLASH state.
// Latency: requests pass a 2-FF synchroniser; lights are registered and change with state on tick.
// Backpressure: none; requests are latched as pending flags until served.
module traffic_phase_sched
    import traffic_pkg::*;
#(
    parameter int TICK_DIV = 100_000_000,
    parameter int T_CLR    = 1,
    parameter int T_GMIN   = 5,
    parameter int T_GMAX   = 12,
    parameter int T_YEL    = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_a,
    input  logic       req_b,
`ifdef NIGHT_FLASH_EN
    input  logic       night,
`endif
    output logic       led4_r,
    output logic       led4_g,
    output logic       led4_b,
    output logic       led5_r,
    output logic       led5_g,
    output logic       led5_b,
    output logic [2:0] phase
);

    localparam int TW = $clog2(T_GMAX + 1);
    localparam logic [TW-1:0] CLR_LAST  = TW'(T_CLR - 1);
    localparam logic [TW-1:0] GMIN_LAST = TW'(T_GMIN - 1);
    localparam logic [TW-1:0] GMAX_LAST = TW'(T_GMAX - 1);
    localparam logic [TW-1:0] YEL_LAST  = TW'(T_YEL - 1);

    logic          tick;
    state_e        state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic          last_b_q, last_b_d;
    logic          pend_a_q, pend_a_d;
    logic          pend_b_q, pend_b_d;
    logic [1:0]    meta_q, meta_d;
    logic [1:0]    sync_q, sync_d;
    logic [2:0]    led_a_q, led_a_d;
    logic [2:0]    led_b_q, led_b_d;
    logic          grant_b;
`ifdef NIGHT_FLASH_EN
    logic          flash_on_q, flash_on_d;
`endif

    tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
        .clk  (clk),
        .rst  (rst),
        .tick (tick)
    );

    always_comb begin
        meta_d = {req_b, req_a};
        sync_d = meta_q;
    end

    always_comb begin
        state_d  = state_q;
        timer_d  = timer_q;
        last_b_d = last_b_q;
        // B wins only when it is alone, or when both wait and A was served last.
        grant_b  = pend_b_q && (!pend_a_q || !last_b_q);
`ifdef NIGHT_FLASH_EN
        flash_on_d = flash_on_q;
`endif
        if (tick) begin
            timer_d = timer_q + 1'b1;
            unique case (state_q)
                ALL_RED: begin
                    if (timer_q == CLR_LAST) begin
                        state_d = grant_b ? B_GREEN : A_GREEN;
`ifdef NIGHT_FLASH_EN
                        if (night) state_d = FLASH;
`endif
                    end
                end
                A_GREEN: begin
                    if (pend_b_q && (timer_q >= GMIN_LAST)) state_d = A_YELLOW;
                    else if (timer_q == GMAX_LAST) timer_d = '0;
`ifdef NIGHT_FLASH_EN
                    if (night) state_d = A_YELLOW;
`endif
                end
                B_GREEN: begin
                    if (pend_a_q && (timer_q >= GMIN_LAST)) state_d = B_YELLOW;
                    else if (timer_q == GMAX_LAST) timer_d = '0;
`ifdef NIGHT_FLASH_EN
                    if (night) state_d = B_YELLOW;
`endif
                end
                A_YELLOW: begin
                    if (timer_q == YEL_LAST) begin
                        last_b_d = 1'b0;
                        state_d  = ALL_RED;
`ifdef NIGHT_FLASH_EN
                        if (night) state_d = FLASH;
`endif
                    end
                end
                B_YELLOW: begin
                    if (timer_q == YEL_LAST) begin
                        last_b_d = 1'b1;
                        state_d  = ALL_RED;
`ifdef NIGHT_FLASH_EN
                        if (night) state_d = FLASH;
`endif
                    end
                end
`ifdef NIGHT_FLASH_EN
                FLASH: begin
                    timer_d    = '0;
                    flash_on_d = !flash_on_q;
                    if (!night) state_d = ALL_RED;
                end
`endif
                default: state_d = ALL_RED;
            endcase
            if (state_d != state_q) timer_d = '0;
        end
`ifdef NIGHT_FLASH_EN
        if ((state_d == FLASH) && (state_q != FLASH)) flash_on_d = 1'b1;
`endif
    end

    always_comb begin
        pend_a_d = pend_a_q | (sync_q[0] && (state_q != A_GREEN));
        pend_b_d = pend_b_q | (sync_q[1] && (state_q != B_GREEN));
        // Entering green clears the served road even if its request is still high.
        if ((state_d == A_GREEN) && (state_q != A_GREEN)) pend_a_d = 1'b0;
        if ((state_d == B_GREEN) && (state_q != B_GREEN)) pend_b_d = 1'b0;
`ifdef NIGHT_FLASH_EN
        if ((state_q == FLASH) && (state_d == ALL_RED)) begin
            pend_a_d = 1'b0;
            pend_b_d = 1'b0;
        end
`endif
    end

    always_comb begin
        led_a_d = RED;
        led_b_d = RED;
        case (state_d)
            A_GREEN:  led_a_d = GREEN;
            A_YELLOW: led_a_d = YELLOW;
            B_GREEN:  led_b_d = GREEN;
            B_YELLOW: led_b_d = YELLOW;
`ifdef NIGHT_FLASH_EN
            FLASH: begin
                led_a_d = flash_on_d ? YELLOW : OFF;
                led_b_d = flash_on_d ? YELLOW : OFF;
            end
`endif
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ALL_RED;
            timer_q  <= '0;
            last_b_q <= 1'b1;
            pend_a_q <= 1'b0;
            pend_b_q <= 1'b0;
            meta_q   <= '0;
            sync_q   <= '0;
            led_a_q  <= RED;
            led_b_q  <= RED;
        end else begin
            state_q  <= state_d;
            timer_q  <= timer_d;
            last_b_q <= last_b_d;
            pend_a_q <= pend_a_d;
            pend_b_q <= pend_b_d;
            meta_q   <= meta_d;
            sync_q   <= sync_d;
            led_a_q  <= led_a_d;
            led_b_q  <= led_b_d;
        end
    end

`ifdef NIGHT_FLASH_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) flash_on_q <= 1'b0;
        else      flash_on_q <= flash_on_d;
    end
`endif

    assign {led4_r, led4_g, led4_b} = led_a_q;
    assign {led5_r, led5_g, led5_b} = led_b_q;
    assign phase = state_q;

endmodule
